// File: rtl/frame_config_loader.sv
// Frame-based configuration loader: deserialises a bit-serial stream into {address, data}
// frames and drives a setup/strobe/hold write sequence to the IO tiles.
module frame_config_loader #(
    parameter int ADDR_WIDTH   = 1,
    parameter int NUM_ADDR     = 2,
    parameter int NUM_FRAMES   = 4,
    parameter int PULSE_CYCLES = 1
) (
    input  logic                              prog_clk,
    input  logic                              pReset,
    input  logic                              start,
    input  logic                              bs_valid,
    input  logic                              bs_bit,
    output logic                              bs_ready,
    output logic [ADDR_WIDTH-1:0]             address,
    output logic                              data_in,
    output logic                              enable,
    output logic                              busy,
    output logic                              done,
    output logic                              addr_err,
    output logic [$clog2(NUM_FRAMES+1)-1:0]   frame_count
);

    localparam int CW = $clog2(NUM_FRAMES + 1);
    localparam int BW = $clog2(ADDR_WIDTH + 2);
    localparam int PW = $clog2(PULSE_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] shift_reg;
    logic [ADDR_WIDTH:0]   shift_next;
    logic [BW-1:0]         bit_cnt;
    logic [PW-1:0]         pulse_cnt;
    logic                  accept;
    logic                  last_bit;
    logic                  pulse_last;
    logic                  in_range;
    logic                  frame_last;
    logic                  run_start;

    assign accept     = (state == LOAD) && bs_valid;
    assign last_bit   = (bit_cnt == BW'(ADDR_WIDTH));
    assign shift_next = {shift_reg, bs_bit};
    assign pulse_last = (pulse_cnt == PW'(PULSE_CYCLES - 1));
    assign in_range   = (32'(address) < 32'(NUM_ADDR));
    assign frame_last = (frame_count == CW'(NUM_FRAMES - 1));
    assign run_start  = ((state == IDLE) || (state == DONE)) && start;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        bs_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        enable     = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = LOAD;
            end
            LOAD: begin
                bs_ready = 1'b1;
                busy     = 1'b1;
                if (accept && last_bit) next_state = SETUP;
            end
            SETUP: begin
                busy       = 1'b1;
                next_state = STROBE;
            end
            STROBE: begin
                busy   = 1'b1;
                // Out-of-range frames still run the full sequence, just without a strobe
                enable = in_range;
                if (pulse_last) next_state = HOLD;
            end
            HOLD: begin
                busy       = 1'b1;
                next_state = frame_last ? DONE : LOAD;
            end
            DONE: begin
                done = 1'b1;
                if (start) next_state = LOAD;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            pulse_cnt   <= '0;
            address     <= '0;
            data_in     <= 1'b0;
            addr_err    <= 1'b0;
            frame_count <= '0;
        end else begin
            if (run_start) begin
                frame_count <= '0;
                addr_err    <= 1'b0;
            end
            // address/data_in only move on the final bit, so they are stable through the strobe
            if (accept) begin
                if (last_bit) begin
                    address   <= shift_next[ADDR_WIDTH:1];
                    data_in   <= shift_next[0];
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end else begin
                    shift_reg <= shift_next[ADDR_WIDTH-1:0];
                    bit_cnt   <= bit_cnt + BW'(1);
                end
            end
            if (state == STROBE) begin
                if (!in_range) addr_err <= 1'b1;
                pulse_cnt <= pulse_last ? '0 : pulse_cnt + PW'(1);
            end
            if ((state == HOLD) && (frame_count != CW'(NUM_FRAMES))) begin
                frame_count <= frame_count + CW'(1);
            end
        end
    end

endmodule
